// File: rtl/fetch_issue_queue.sv
// Fetch-to-decode instruction queue: compacts masked 2-word fetch packets into a
// circular buffer and presents the two oldest entries. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [63:0]      fetch_instr,
  input  logic [1:0]       fetch_mask,
  output logic             fetch_ready,
  input  logic [1:0]       issue_cnt,
  output logic             out_valid_a,
  output logic [31:0]      out_pc_a,
  output logic [31:0]      out_instr_a,
  output logic             out_valid_b,
  output logic [31:0]      out_pc_b,
  output logic [31:0]      out_instr_b,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] L_READY_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_mem_pc    [DEPTH];
  logic [31:0]      r_mem_instr [DEPTH];

  logic             w_enq_fire;
  logic             w_byp;
  logic [1:0]       w_issue_req;
  logic [1:0]       w_words;
  logic [1:0]       w_deq_q;
  logic [1:0]       w_deq_b;
  logic [1:0]       w_wr_n;
  logic [31:0]      w_c0_pc;
  logic [31:0]      w_c0_instr;
  logic [31:0]      w_c1_pc;
  logic [31:0]      w_c1_instr;
  logic [31:0]      w_w0_pc;
  logic [31:0]      w_w0_instr;
  logic [PTR_W-1:0] w_wr_ptr1;
  logic [PTR_W-1:0] w_rd_ptr1;

  assign fetch_ready = (r_count <= L_READY_MAX);
  assign count       = r_count;
  assign w_enq_fire  = fetch_valid && fetch_ready;
  assign w_issue_req = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
  assign w_words     = {1'b0, fetch_mask[0]} + {1'b0, fetch_mask[1]};
  assign w_wr_ptr1   = r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr1   = r_rd_ptr + PTR_W'(1);

  // Compacted candidates: slot 0 is the oldest valid word of the packet.
  assign w_c0_pc    = fetch_mask[0] ? fetch_pc : fetch_pc + 32'd4;
  assign w_c0_instr = fetch_mask[0] ? fetch_instr[31:0] : fetch_instr[63:32];
  assign w_c1_pc    = fetch_pc + 32'd4;
  assign w_c1_instr = fetch_instr[63:32];

  assign w_deq_q = ((PTR_W+1)'(w_issue_req) > r_count) ? r_count[1:0] : w_issue_req;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_enq_fire && (r_count == '0) && (w_words != 2'd0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_deq_b = w_byp ? ((w_issue_req > w_words) ? w_words : w_issue_req) : 2'd0;
  assign w_wr_n  = w_enq_fire ? (w_words - w_deq_b) : 2'd0;

  // With one bypassed word consumed, only the younger word is stored.
  assign w_w0_pc    = (w_deq_b == 2'd1) ? w_c1_pc : w_c0_pc;
  assign w_w0_instr = (w_deq_b == 2'd1) ? w_c1_instr : w_c0_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_wr_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq_q);
      r_count  <= r_count + (PTR_W+1)'(w_wr_n) - (PTR_W+1)'(w_deq_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      if (w_wr_n != 2'd0) begin
        r_mem_pc[r_wr_ptr]    <= w_w0_pc;
        r_mem_instr[r_wr_ptr] <= w_w0_instr;
      end
      if (w_wr_n == 2'd2) begin
        r_mem_pc[w_wr_ptr1]    <= w_c1_pc;
        r_mem_instr[w_wr_ptr1] <= w_c1_instr;
      end
    end
  end

  always_comb begin
    out_valid_a = 1'b0;
    out_pc_a    = '0;
    out_instr_a = '0;
    out_valid_b = 1'b0;
    out_pc_b    = '0;
    out_instr_b = '0;
    if (w_byp) begin
      out_valid_a = 1'b1;
      out_pc_a    = w_c0_pc;
      out_instr_a = w_c0_instr;
      if (w_words == 2'd2) begin
        out_valid_b = 1'b1;
        out_pc_b    = w_c1_pc;
        out_instr_b = w_c1_instr;
      end
    end else begin
      if (r_count != '0) begin
        out_valid_a = 1'b1;
        out_pc_a    = r_mem_pc[r_rd_ptr];
        out_instr_a = r_mem_instr[r_rd_ptr];
      end
      if (r_count >= (PTR_W+1)'(2)) begin
        out_valid_b = 1'b1;
        out_pc_b    = r_mem_pc[w_rd_ptr1];
        out_instr_b = r_mem_instr[w_rd_ptr1];
      end
    end
  end

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Instruction buffer and issue scheduler between the dual-word fetch selector and the decode stage.
- Accepts 64-bit fetch packets, each with a per-word valid mask, and compacts the valid words into a single-instruction circular queue.
- Presents the two oldest instructions to decode every cycle and retires 0, 1 or 2 per cycle, as decode reports.
- Decouples fetch from decode stalls and single/dual-issue decisions; flushed on branch redirect or exception.

Parameters:
- DEPTH, 8, queue capacity in instructions; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear (redirect/exception).
- fetch_valid  in  1  a fetch packet is offered.
- fetch_pc  in  32  PC of the low word; the high word's PC is fetch_pc+4.
- fetch_instr  in  64  [31:0] low word, [63:32] high word.
- fetch_mask  in  2  bit0 low word valid, bit1 high word valid.
- fetch_ready  out  1  queue accepts a packet this cycle.
- issue_cnt  in  2  number of instructions decode consumes this cycle (0..2).
- out_valid_a  out  1  head entry valid.
- out_pc_a  out  32  head PC.
- out_instr_a  out  32  head instruction.
- out_valid_b  out  1  second entry valid.
- out_pc_b  out  32  second PC.
- out_instr_b  out  32  second instruction.
- count  out  PTR_W+1  occupied entries.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}; wr_ptr and rd_ptr wrap modulo DEPTH; count tracked explicitly, range 0..DEPTH.
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0. Outputs: fetch_ready=1, out_valid_a/b=0, out_pc/instr_a/b=0. Storage contents are not reset.
- fetch_ready = (DEPTH-count >= 2). It is computed from registered count only; same-cycle dequeue is not credited.
- Enqueue fires when fetch_valid && fetch_ready, in order low word then high word:
  - mask 11: two entries, {fetch_pc, low} then {fetch_pc+4, high}.
  - mask 01: one entry {fetch_pc, low}.
  - mask 10: one entry {fetch_pc+4, high}.
  - mask 00: no write; the packet is consumed.
- A two-entry write at wr_ptr=DEPTH-1 writes slots DEPTH-1 and 0.
- Issue outputs are combinational from registered state:
  - out_valid_a = (count>=1); out_valid_b = (count>=2).
  - A holds entry rd_ptr; B holds entry rd_ptr+1 (mod DEPTH).
  - PC/instr of an invalid port are driven 0.
- Dequeue: deq = min(issue_cnt, count). Excess requests are clamped, not an error; issue_cnt=3 is treated as 2. rd_ptr advances by deq.
- Simultaneous enqueue and dequeue: count_next = count + enq - deq. Data enqueued in cycle N is first visible at the outputs in cycle N+1.
- Flush (sync, when reset=1): wr_ptr=rd_ptr=count=0 next cycle. Same-cycle enqueue and dequeue are discarded. Outputs in the flush cycle still reflect pre-flush state.
- Async reset overrides flush and everything else. Reset asserted mid-operation empties the queue immediately.
- No overflow is possible given the fetch_ready rule. Underflow is prevented by the clamp.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0 and an enqueue fires, the incoming valid words drive the A/B outputs combinationally in the same cycle, compacted as above.
  - issue_cnt may consume them that cycle; deq is clamped to the number of incoming words.
  - Only unconsumed words are written to storage.
  - count_next = words - deq.
- Undefined: no bypass; minimum fetch-to-issue latency is 1 cycle.

Test Plan:
- Reset release, then packet pc=0x100, mask=11, instr={0xBBBB0000,0xAAAA0000}, issue_cnt=0:
  - Next cycle: A = {0x100, 0xAAAA0000}, B = {0x104, 0xBBBB0000}, count=2.
- Mask 10 at pc=0x200 into an empty queue, issue_cnt=0:
  - Next cycle: only A valid, out_pc_a=0x204; out_valid_b=0, out_pc_b=0, out_instr_b=0.
- Fill to count=7 with DEPTH=8:
  - fetch_ready=0; the offered packet is not accepted, count stays 7.
  - Issue 1 → count=6 and fetch_ready=1 next cycle.
- wr_ptr=7, rd_ptr=7, count=0; enqueue mask 11 at pc=0x300; then issue_cnt=2:
  - Outputs 0x300 then 0x304 (slots 7 and 0); count returns to 0, rd_ptr=1.
- count=1, issue_cnt=2, simultaneous enqueue mask 11:
  - deq clamped to 1; count becomes 2; the new pair appears at A/B.
- count=5 with flush=1 plus a concurrent enqueue:
  - Next cycle count=0, both out_valid=0, fetch_ready=1.
  - Asserting reset=0 mid-sequence clears outputs without waiting for a clock edge.
